// File: rtl/cmd_encoder.sv
// Host command encoder: frames write and convolve requests into a byte
// stream of opcode, memory select, length and payload, or opcode and trigger.
module cmd_encoder #(
  parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_mem,
  input  logic [15:0] req_len,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_SEL, S_LLSB,
    S_LMSB, S_DATA, S_TRIG, S_FIN
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [2:0]  r_mem;
  logic [15:0] r_len;
  logic [15:0] r_rem;
  logic        r_err;

  logic        w_req_xfer;
  logic        w_tx_xfer;
  logic        w_wr_xfer;
  logic        w_bad;
  logic        w_hdr_st;
  logic        w_data_st;
  logic [7:0]  w_hdr;

  assign w_req_xfer = req_valid && req_ready;
  assign w_tx_xfer  = tx_valid && tx_ready;
  assign w_wr_xfer  = wr_valid && wr_ready;
  assign w_bad      = (req_op == 2'd0) &&
                      ((req_mem > 3'd6) || (req_len > MAX_LEN));

  assign w_hdr_st  = r_state inside {S_OPC, S_SEL, S_LLSB,
                                     S_LMSB, S_TRIG};
  assign w_data_st = (r_state == S_DATA);

  always_comb begin
    w_hdr = 8'h00;
    unique case (r_state)
      S_OPC:   w_hdr = (r_op == 2'd0) ? 8'h19
                                      : {6'b001000, r_op};
      S_SEL:   w_hdr = {5'b0, r_mem};
      S_LLSB:  w_hdr = r_len[7:0];
      S_LMSB:  w_hdr = r_len[15:8];
      default: w_hdr = 8'h00;
    endcase
  end

  // Payload bytes pass straight through, so a held wr byte is a held tx byte
  // and throughput stays at one byte per cycle.
  assign tx_valid  = !reset &&
                     (w_hdr_st || (w_data_st && wr_valid));
  assign tx_data   = reset     ? 8'h00 :
                     w_data_st ? (wr_valid ? wr_data : 8'h00) :
                                 w_hdr;
  assign wr_ready  = !reset && w_data_st && tx_ready;
  assign req_ready = !reset && (r_state == S_IDLE);
  assign busy      = !reset && (r_state != S_IDLE);
  assign done      = !reset && (r_state == S_FIN);
  assign err       = !reset && r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_mem   <= 3'd0;
      r_len   <= 16'd0;
      r_rem   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req_xfer) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_op    <= req_op;
              r_mem   <= req_mem;
              r_len   <= req_len;
              r_rem   <= req_len;
              r_state <= S_OPC;
            end
          end
        end
        S_OPC: if (w_tx_xfer)
          r_state <= (r_op == 2'd0) ? S_SEL : S_TRIG;
        S_SEL: if (w_tx_xfer)
          r_state <= S_LLSB;
        S_LLSB: if (w_tx_xfer)
          r_state <= S_LMSB;
        S_LMSB: if (w_tx_xfer)
          r_state <= (r_len != 16'd0) ? S_DATA : S_FIN;
        S_DATA: begin
          if (w_wr_xfer) begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1)
              r_state <= S_FIN;
          end
        end
        S_TRIG: if (w_tx_xfer)
          r_state <= S_FIN;
        S_FIN:
          r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// Directed bench for cmd_encoder: frame contents, handshakes,
// error drop, backpressure stability and mid-frame reset.
module tb_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [2:0]  req_mem = 3'd0;
  logic [15:0] req_len = 16'd0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;
  int dcnt = 0;
  int ecnt = 0;
  int wcnt = 0;
  logic [7:0] rx[$];
  logic [7:0] pl[$];
  logic       pend = 1'b0;
  logic [7:0] pdata = 8'h00;

  cmd_encoder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mem(req_mem), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Transfers complete on the following rising edge; record them here.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    if (done) dcnt++;
    if (err) ecnt++;
    if (wr_ready) wcnt++;
    if (!reset && pend) begin
      total++;
      if (!tx_valid || tx_data !== pdata) begin
        bad++;
        $display("FAIL stall_hold: got v=%0b d=%02h want v=1 d=%02h",
                 tx_valid, tx_data, pdata);
      end
    end
    pend  = !reset && tx_valid && !tx_ready;
    pdata = tx_data;
  end

  task automatic do_req(input logic [1:0] op, input logic [2:0] mem,
                        input logic [15:0] len, output bit acc);
    req_valid = 1'b1;
    req_op = op;
    req_mem = mem;
    req_len = len;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); #1;
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int budget,
                           output int cyc, output bit ok);
    int idx;
    int d0;
    bit xf;
    idx = 0;
    d0 = dcnt;
    ok = 1'b0;
    cyc = 0;
    tx_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
    wr_valid = (pl.size() > 0) && (rnd ? $urandom % 2 == 1 : 1'b1);
    wr_data = (pl.size() > 0) ? pl[0] : 8'h00;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk); #1;
      xf = wr_valid && wr_ready;
      cyc = c;
      if (dcnt != d0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (xf) idx++;
      if (!(wr_valid && !xf)) begin
        wr_valid = (idx < pl.size()) &&
                   (rnd ? $urandom % 2 == 1 : 1'b1);
        wr_data = (idx < pl.size()) ? pl[idx] : 8'h00;
      end
      tx_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ({req_ready, wr_ready, tx_valid, busy, done, err} !== 6'b0 ||
        tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outs: got rr=%0b wr=%0b tv=%0b td=%02h b=%0b d=%0b e=%0b want all 0",
               req_ready, wr_ready, tx_valid, tx_data, busy, done, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rr=%0b busy=%0b want rr=1 busy=0",
               req_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    logic [7:0] exp[7];
    bit acc;
    bit ok;
    int cyc;
    int d0;
    exp = '{8'h19, 8'h02, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    pl = '{8'hAA, 8'hBB, 8'hCC};
    rx.delete();
    d0 = dcnt;
    do_req(2'd0, 3'd2, 16'd3, acc);
    run_frame(1'b0, 50, cyc, ok);
    total++;
    if (!acc || !ok) begin
      bad++;
      $display("FAIL write_done: got acc=%0b done=%0b want 1 1", acc, ok);
    end
    total++;
    if (rx.size() != 7) begin
      bad++;
      $display("FAIL write_len: got %0d bytes want 7", rx.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (rx[i] !== exp[i]) begin
          bad++;
          $display("FAIL write_byte%0d: got %02h want %02h",
                   i, rx[i], exp[i]);
        end
      end
    end
    total++;
    if (cyc > 9) begin
      bad++;
      $display("FAIL write_latency: got %0d cycles want <= 9", cyc);
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (dcnt - d0 != 1) begin
      bad++;
      $display("FAIL write_pulses: got %0d done pulses want 1", dcnt - d0);
    end
  endtask

  task automatic test_convolve;
    bit acc;
    bit ok;
    int cyc;
    int w0;
    pl.delete();
    rx.delete();
    w0 = wcnt;
    do_req(2'd3, 3'd0, 16'd0, acc);
    run_frame(1'b0, 20, cyc, ok);
    total++;
    if (!acc || !ok || rx.size() != 2) begin
      bad++;
      $display("FAIL conv_frame: got acc=%0b done=%0b n=%0d want 1 1 2",
               acc, ok, rx.size());
    end else begin
      total++;
      if (rx[0] !== 8'h23 || rx[1] !== 8'h00) begin
        bad++;
        $display("FAIL conv_bytes: got %02h %02h want 23 00",
                 rx[0], rx[1]);
      end
    end
    total++;
    if (wcnt != w0) begin
      bad++;
      $display("FAIL conv_wr_ready: got %0d cycles high want 0", wcnt - w0);
    end
  endtask

  task automatic test_len0;
    logic [7:0] exp[4];
    bit acc;
    bit ok;
    int cyc;
    exp = '{8'h19, 8'h06, 8'h00, 8'h00};
    pl.delete();
    rx.delete();
    do_req(2'd0, 3'd6, 16'd0, acc);
    run_frame(1'b0, 20, cyc, ok);
    total++;
    if (!acc || !ok || rx.size() != 4) begin
      bad++;
      $display("FAIL len0_frame: got acc=%0b done=%0b n=%0d want 1 1 4",
               acc, ok, rx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rx[i] !== exp[i]) begin
          bad++;
          $display("FAIL len0_byte%0d: got %02h want %02h",
                   i, rx[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_err;
    bit acc;
    int e0;
    rx.delete();
    e0 = ecnt;
    do_req(2'd0, 3'd7, 16'd4, acc);
    @(negedge clk); #1;
    total++;
    if (!acc || err !== 1'b1 || tx_valid !== 1'b0 ||
        req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse: got acc=%0b e=%0b tv=%0b rr=%0b b=%0b want 1 1 0 1 0",
               acc, err, tx_valid, req_ready, busy);
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    total++;
    if (err !== 1'b0 || ecnt - e0 != 1 || rx.size() != 0) begin
      bad++;
      $display("FAIL err_once: got e=%0b pulses=%0d bytes=%0d want 0 1 0",
               err, ecnt - e0, rx.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit acc;
    bit ok;
    int cyc;
    int nbad;
    logic [7:0] exp[$];
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'((i * 37 + 11) ^ (i >> 3)));
    exp = '{8'h19, 8'h04, 8'h00, 8'h01};
    foreach (pl[i]) exp.push_back(pl[i]);
    rx.delete();
    do_req(2'd0, 3'd4, 16'd256, acc);
    run_frame(1'b1, 5000, cyc, ok);
    total++;
    if (!acc || !ok || rx.size() != exp.size()) begin
      bad++;
      $display("FAIL bp_frame: got acc=%0b done=%0b n=%0d want 1 1 %0d",
               acc, ok, rx.size(), exp.size());
    end else begin
      nbad = 0;
      foreach (exp[i]) if (rx[i] !== exp[i]) nbad++;
      total++;
      if (nbad != 0) begin
        bad++;
        $display("FAIL bp_stream: got %0d wrong bytes want 0", nbad);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    bit ok;
    int cyc;
    int d0;
    int e0;
    int idx;
    bit hit;
    rx.delete();
    d0 = dcnt;
    e0 = ecnt;
    do_req(2'd0, 3'd1, 16'd10, acc);
    tx_ready = 1'b1;
    idx = 0;
    hit = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'h50;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk); #1;
      if (wr_valid && wr_ready) idx++;
      if (rx.size() == 9) hit = 1'b1;
      @(posedge clk); #1;
      wr_data = 8'(8'h50 + idx);
    end
    reset = 1'b1;
    wr_valid = 1'b0;
    total++;
    if (!acc || !hit || idx != 5) begin
      bad++;
      $display("FAIL mid_setup: got acc=%0b hit=%0b sent=%0d want 1 1 5",
               acc, hit, idx);
    end
    @(negedge clk); #1;
    total++;
    if ({req_ready, wr_ready, tx_valid, busy, done, err} !== 6'b0) begin
      bad++;
      $display("FAIL mid_outs: got rr=%0b wr=%0b tv=%0b b=%0b d=%0b e=%0b want all 0",
               req_ready, wr_ready, tx_valid, busy, done, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || dcnt != d0 || ecnt != e0 || rx.size() != 9) begin
      bad++;
      $display("FAIL mid_abort: got rr=%0b done=%0d err=%0d n=%0d want 1 0 0 9",
               req_ready, dcnt - d0, ecnt - e0, rx.size());
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    pl.delete();
    rx.delete();
    do_req(2'd1, 3'd0, 16'd0, acc);
    run_frame(1'b0, 20, cyc, ok);
    total++;
    if (!acc || !ok || rx.size() != 2) begin
      bad++;
      $display("FAIL mid_conv: got acc=%0b done=%0b n=%0d want 1 1 2",
               acc, ok, rx.size());
    end else begin
      total++;
      if (rx[0] !== 8'h21 || rx[1] !== 8'h00) begin
        bad++;
        $display("FAIL mid_conv_bytes: got %02h %02h want 21 00",
                 rx[0], rx[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_convolve();
    test_len0();
    test_err();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
